obi_data_mem: RTL and testbench

OBI data-memory responder sitting directly downstream of the cv32e40p LSU. It consumes the LSU's data-bus request (req/addr/we/be/wdata/atop) and returns grant, in-order read/write responses and read data. It is a synthesizable word RAM with a bounded outstanding-response queue, configurable response latency and testbench-controlled grant/response stalls. Verification benches use it as the LSU's memory so that misaligned, back-to-back and stalled traffic can be exercised.

---
 rtl/obi_data_mem.sv | 113 +++++++++++
 tb/tb_obi_data_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/obi_data_mem.sv
// OBI data-memory responder for the cv32e40p LSU: word RAM with an
// in-order response queue, configurable latency and bench-driven stalls.
module obi_data_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_LAT   = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic [5:0]  data_atop_i,
  input  logic        gnt_stall_i,
  input  logic        rvalid_stall_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int CW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int NW = $clog2(RESP_DEPTH + 1);
  localparam int QN = 2 ** PW;

  typedef struct packed {
    logic [31:0]   rdata;
    logic          err;
    logic [CW-1:0] cnt;
  } ent_t;

  logic [31:0] mem [2**ADDR_WIDTH];
  ent_t        q [QN];

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [NW-1:0] count;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  oor;
  logic                  pop;
  logic                  push;
  ent_t                  head;
  ent_t                  new_ent;
  logic                  unused_bits;

  assign unused_bits = ^{data_atop_i, data_addr_i[1:0]};

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign idx  = data_addr_i[ADDR_WIDTH+1:2];
  assign oor  = |data_addr_i[31:ADDR_WIDTH+2];
  assign head = q[head_ptr];

  // Head may only retire once its latency countdown has expired.
  assign pop = ~rst & (count != '0) & (head.cnt == '0)
             & ~rvalid_stall_i;

  assign data_gnt_o = data_req_i & ~rst & ~gnt_stall_i
                    & ((count < NW'(RESP_DEPTH)) | pop);
  assign push = data_gnt_o;

  always_comb begin
    new_ent       = '0;
    new_ent.err   = oor;
    new_ent.cnt   = CW'(RESP_LAT - 1);
    if (~data_we_i & ~oor) begin
      new_ent.rdata = mem[idx];
    end
  end

  assign data_rvalid_o = pop;
  assign data_rdata_o  = pop ? head.rdata : '0;
  assign data_err_o    = pop ? head.err : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= ptr_next(tail_ptr);
      if (pop) head_ptr <= ptr_next(head_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stale slots may count down too; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QN; i++) begin
      if (q[i].cnt != '0) q[i].cnt <= q[i].cnt - CW'(1);
    end
    if (push) q[tail_ptr] <= new_ent;
  end

  always_ff @(posedge clk) begin
    if (push & data_we_i & ~oor) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_obi_data_mem.sv
// Bench for obi_data_mem: transaction-level model with random traffic
// plus directed write/read, byte-enable, stall, latency and reset cases.
module tb_obi_data_mem;

  localparam int LAT = 1;
  localparam int DEP = 2;

  logic clk;
  int checks = 0;
  int errors = 0;

  logic        a_rst, a_req, a_we, a_gs, a_rs;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic [5:0]  a_atop;
  logic        a_gnt, a_rv, a_err;
  logic [31:0] a_rd;

  logic        b_rst, b_req, b_we;
  logic [31:0] b_addr, b_wdata;
  logic        b_gnt, b_rv, b_err;
  logic [31:0] b_rd;

  logic        o_gnt, o_rv, o_err;
  logic [31:0] o_rd;

  obi_data_mem #(.ADDR_WIDTH(10), .RESP_LAT(LAT), .RESP_DEPTH(DEP)) u_a (
    .clk(clk), .rst(a_rst), .data_req_i(a_req), .data_addr_i(a_addr),
    .data_we_i(a_we), .data_be_i(a_be), .data_wdata_i(a_wdata),
    .data_atop_i(a_atop), .gnt_stall_i(a_gs), .rvalid_stall_i(a_rs),
    .data_gnt_o(a_gnt), .data_rvalid_o(a_rv), .data_rdata_o(a_rd),
    .data_err_o(a_err)
  );

  obi_data_mem #(.ADDR_WIDTH(10), .RESP_LAT(3), .RESP_DEPTH(1)) u_b (
    .clk(clk), .rst(b_rst), .data_req_i(b_req), .data_addr_i(b_addr),
    .data_we_i(b_we), .data_be_i(4'hF), .data_wdata_i(b_wdata),
    .data_atop_i(6'd0), .gnt_stall_i(1'b0), .rvalid_stall_i(1'b0),
    .data_gnt_o(b_gnt), .data_rvalid_o(b_rv), .data_rdata_o(b_rd),
    .data_err_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_m [int];
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic req, input logic we,
                      input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic gs,
                      input logic rs, input logic r);
    logic        pv, eg, oor;
    logic [31:0] erd, w;
    logic        eer;
    ent_t        e;
    @(negedge clk);
    a_rst = r; a_req = req; a_we = we; a_be = be;
    a_addr = addr; a_wdata = wdata; a_gs = gs; a_rs = rs;
    a_atop = 6'($urandom);
    #1;
    pv  = !r && q.size() > 0 && !rs && q[0].due <= cyc;
    eg  = req && !r && !gs && (q.size() < DEP || pv);
    erd = pv ? q[0].rdata : 32'h0;
    eer = pv ? q[0].err : 1'b0;
    o_gnt = a_gnt; o_rv = a_rv; o_rd = a_rd; o_err = a_err;
    chk("gnt", {31'h0, a_gnt}, {31'h0, eg});
    chk("rvalid", {31'h0, a_rv}, {31'h0, pv});
    chk("rdata", a_rd, erd);
    chk("err", {31'h0, a_err}, {31'h0, eer});
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (pv) void'(q.pop_front());
      if (eg) begin
        oor     = addr >= 32'h1000;
        e.rdata = (!we && !oor) ? mem_m[int'(addr >> 2)] : 32'h0;
        e.err   = oor;
        e.due   = cyc + LAT;
        q.push_back(e);
        if (we && !oor) begin
          w = mem_m.exists(int'(addr >> 2)) ? mem_m[int'(addr >> 2)] : 32'h0;
          for (int k = 0; k < 4; k++)
            if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
          mem_m[int'(addr >> 2)] = w;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input logic rs);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, rs, 1'b0);
  endtask

  task automatic bstep(input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic r);
    @(negedge clk);
    b_rst = r; b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    #1;
    o_gnt = b_gnt; o_rv = b_rv; o_rd = b_rd; o_err = b_err;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] w0;
    logic        req, we, gs, rs, r;
    logic [3:0]  be;
    logic [31:0] addr;
    a_rst = 1'b1; a_req = 1'b0; a_we = 1'b0; a_be = 4'h0;
    a_addr = '0; a_wdata = '0; a_atop = '0; a_gs = 1'b0; a_rs = 1'b0;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    step(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'hF, 32'h10, 32'h1, 1'b0, 1'b0, 1'b1);
    chk("rst_gnt", {31'h0, o_gnt}, 32'h0);
    chk("rst_rvalid", {31'h0, o_rv}, 32'h0);

    w0 = $urandom;
    step(1'b1, 1'b1, 4'hF, 32'h0, w0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++)
      step(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    step(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("wr_gnt", {31'h0, o_gnt}, 32'h1);
    step(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rd_gnt", {31'h0, o_gnt}, 32'h1);
    chk("wr_resp_rdata", o_rd, 32'h0);
    idle(1'b0);
    chk("rd_resp_valid", {31'h0, o_rv}, 32'h1);
    chk("rd_back", o_rd, 32'hDEADBEEF);

    step(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("byte_en", o_rd, 32'h11BB33DD);

    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_gnt1", {31'h0, o_gnt}, 32'h1);
    step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_gnt2", {31'h0, o_gnt}, 32'h1);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_gnt3_full", {31'h0, o_gnt}, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_gnt4_full", {31'h0, o_gnt}, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("bp_gnt_on_pop", {31'h0, o_gnt}, 32'h1);
    chk("bp_first_resp", o_rd, 32'hDEADBEEF);
    step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("bp_second_resp", o_rd, 32'h11BB33DD);
    idle(1'b0);
    chk("bp_third_resp", o_rd, w0);
    idle(1'b0);
    idle(1'b0);

    step(1'b1, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("oor_err", {31'h0, o_err}, 32'h1);
    chk("oor_rdata", o_rd, 32'h0);
    idle(1'b0);
    chk("oor_word0", o_rd, w0);
    chk("oor_rd_err", {31'h0, o_err}, 32'h0);

    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_gnt", {31'h0, o_gnt}, 32'h1);
    chk("rst_mid_rv", {31'h0, o_rv}, 32'h0);
    idle(1'b0);
    chk("rst_mid_resp", o_rd, 32'hDEADBEEF);
    idle(1'b0);
    chk("rst_mid_drop", {31'h0, o_rv}, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      r    = ($urandom_range(0, 199) == 0);
      req  = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom);
      gs   = ($urandom_range(0, 5) == 0);
      rs   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h1000;
      else addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      step(req, we, be, addr, $urandom, gs, rs, r);
    end
    for (int i = 0; i < 4; i++) idle(1'b0);

    bstep(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    bstep(1'b1, 1'b1, 32'h0, 32'h5A5A0001, 1'b0);
    chk("lat_wr_gnt", {31'h0, o_gnt}, 32'h1);
    bstep(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lat_full_gnt", {31'h0, o_gnt}, 32'h0);
    chk("lat_n1_rv", {31'h0, o_rv}, 32'h0);
    bstep(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lat_n2_rv", {31'h0, o_rv}, 32'h0);
    bstep(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lat_n3_rv", {31'h0, o_rv}, 32'h1);
    chk("lat_n3_gnt", {31'h0, o_gnt}, 32'h1);
    chk("lat_wr_rdata", o_rd, 32'h0);
    bstep(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lat_rd_n1", {31'h0, o_rv}, 32'h0);
    bstep(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lat_rd_n2", {31'h0, o_rv}, 32'h0);
    bstep(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lat_rd_n3", {31'h0, o_rv}, 32'h1);
    chk("lat_rd_data", o_rd, 32'h5A5A0001);
    bstep(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lat_rd_once", {31'h0, o_rv}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
